// File: rtl/piece_if.sv
// Bus between the falling-piece controller and the board/game logic.
// Grouped so one modport pair describes every direction in one place.
interface piece_if;
  logic        start;
  logic        tick;
  logic        req_left;
  logic        req_right;
  logic        req_down;
  logic [19:0] spawn_x;
  logic [23:0] spawn_y;
  logic [19:0] q_x;
  logic [23:0] q_y;
  logic        q_valid;
  logic        q_hit;
  logic [19:0] piece_x;
  logic [23:0] piece_y;
  logic        piece_valid;
  logic        lock_valid;
  logic        lock_ready;
  logic        game_over;
  logic        busy;
  logic [15:0] pieces;

  // Lock handshake: a transfer happens on any rising edge where lock_valid
  // and lock_ready are both 1; lock_valid and piece_x/piece_y stay stable
  // until then, and lock_ready may already be 1 when lock_valid rises.
  // Query: q_hit answers the q_valid strobe of the previous cycle.
  modport master (
    input  start, tick, req_left, req_right, req_down, spawn_x, spawn_y,
           q_hit, lock_ready,
    output q_x, q_y, q_valid, piece_x, piece_y, piece_valid, lock_valid,
           game_over, busy, pieces
  );

  modport slave (
    output start, tick, req_left, req_right, req_down, spawn_x, spawn_y,
           q_hit, lock_ready,
    input  q_x, q_y, q_valid, piece_x, piece_y, piece_valid, lock_valid,
           game_over, busy, pieces
  );
endinterface

// File: rtl/piece_controller.sv
// Falling-piece controller: spawns, moves and locks a 4-cell piece,
// asking the board for occupancy before every committed move.
module piece_controller #(
  parameter int BOARD_W = 20,
  parameter int BOARD_H = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  piece_if.master     bus,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_SPAWN_CHK, S_ACTIVE, S_CHK, S_LOCK, S_OVER
  } state_t;

  localparam logic [4:0] X_MAX = 5'(BOARD_W - 1);
  localparam logic [5:0] Y_MAX = 6'(BOARD_H - 1);

  state_t      state_q;
  logic [19:0] cand_x_q, piece_x_q;
  logic [23:0] cand_y_q, piece_y_q;
  logic        piece_valid_q, lock_valid_q, game_over_q, move_down_q;
  logic [15:0] pieces_q;

  logic [19:0] lf_x, rt_x, cand_x_d;
  logic [23:0] dn_y, cand_y_d;
  logic        at_left, at_right, at_bottom;
  logic        mv_down, mv_left, mv_right, issue;

  always_comb begin
    lf_x      = '0;
    rt_x      = '0;
    dn_y      = '0;
    at_left   = 1'b0;
    at_right  = 1'b0;
    at_bottom = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lf_x[i*5 +: 5] = piece_x_q[i*5 +: 5] - 5'd1;
      rt_x[i*5 +: 5] = piece_x_q[i*5 +: 5] + 5'd1;
      dn_y[i*6 +: 6] = piece_y_q[i*6 +: 6] + 6'd1;
      if (piece_x_q[i*5 +: 5] == 5'd0)  at_left   = 1'b1;
      if (piece_x_q[i*5 +: 5] == X_MAX) at_right  = 1'b1;
      if (piece_y_q[i*6 +: 6] == Y_MAX) at_bottom = 1'b1;
    end
  end

  // Gravity and soft-drop share one down move; only one move per cycle.
  assign mv_down  = bus.tick | bus.req_down;
  assign mv_left  = ~mv_down & bus.req_left;
  assign mv_right = ~mv_down & ~bus.req_left & bus.req_right;
  assign issue    = (mv_down & ~at_bottom) | (mv_left & ~at_left) |
                    (mv_right & ~at_right);

  always_comb begin
    cand_x_d = piece_x_q;
    cand_y_d = piece_y_q;
    if (mv_down)       cand_y_d = dn_y;
    else if (mv_left)  cand_x_d = lf_x;
    else if (mv_right) cand_x_d = rt_x;
  end

  // The ACTIVE query must go out in the request cycle so q_hit lands in CHK.
  assign bus.q_valid = (state_q == S_SPAWN) | ((state_q == S_ACTIVE) & issue);
  assign bus.q_x     = (state_q == S_SPAWN) ? bus.spawn_x : cand_x_d;
  assign bus.q_y     = (state_q == S_SPAWN) ? bus.spawn_y : cand_y_d;

  assign bus.piece_x     = piece_x_q;
  assign bus.piece_y     = piece_y_q;
  assign bus.piece_valid = piece_valid_q;
  assign bus.lock_valid  = lock_valid_q;
  assign bus.game_over   = game_over_q;
  assign bus.pieces      = pieces_q;
  assign bus.busy        = (state_q != S_ACTIVE) && (state_q != S_IDLE) &&
                           (state_q != S_OVER);
  assign state_o         = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      piece_x_q     <= '0;
      piece_y_q     <= '0;
      piece_valid_q <= 1'b0;
      lock_valid_q  <= 1'b0;
      game_over_q   <= 1'b0;
      move_down_q   <= 1'b0;
      pieces_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_q <= S_SPAWN;
        S_SPAWN: begin
          cand_x_q <= bus.spawn_x;
          cand_y_q <= bus.spawn_y;
          state_q  <= S_SPAWN_CHK;
        end
        S_SPAWN_CHK: begin
          if (bus.q_hit) begin
            game_over_q   <= 1'b1;
            piece_valid_q <= 1'b0;
            state_q       <= S_OVER;
          end else begin
            piece_x_q     <= cand_x_q;
            piece_y_q     <= cand_y_q;
            piece_valid_q <= 1'b1;
            state_q       <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (mv_down && at_bottom) begin
            lock_valid_q <= 1'b1;
            state_q      <= S_LOCK;
          end else if (issue) begin
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            move_down_q <= mv_down;
            state_q     <= S_CHK;
          end
        end
        S_CHK: begin
          if (!bus.q_hit) begin
            piece_x_q <= cand_x_q;
            piece_y_q <= cand_y_q;
            state_q   <= S_ACTIVE;
          end else if (move_down_q) begin
            lock_valid_q <= 1'b1;
            state_q      <= S_LOCK;
          end else begin
            state_q <= S_ACTIVE;
          end
        end
        S_LOCK: begin
          if (bus.lock_ready) begin
            if (pieces_q != 16'hFFFF) pieces_q <= pieces_q + 16'd1;
            lock_valid_q  <= 1'b0;
            piece_valid_q <= 1'b0;
            state_q       <= S_SPAWN;
          end
        end
        S_OVER: begin
          if (bus.start) begin
            game_over_q <= 1'b0;
            pieces_q    <= '0;
            state_q     <= S_SPAWN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/piece_controller.md
PIECE_CONTROLLER -- requirements
Module: piece_controller

Interface
REQ-001 Parameter BOARD_W, default 20: board columns; legal x = 0..BOARD_W-1.
REQ-002 Parameter BOARD_H, default 24: board rows; legal y = 0..BOARD_H-1, row 0 at top.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high: Clk  in  1  rising-edge clock.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin game; honored only in IDLE and OVER.
REQ-006 tick  in  1  gravity pulse, one cycle wide.
REQ-007 req_left, req_right, req_down  in  1 each  player move requests, level-sampled.
REQ-008 spawn_x  in  20  four 5-bit spawn x coordinates, cell0 in [4:0]; spawn_y  in  24  four 6-bit spawn y coordinates, cell0 in [5:0].
REQ-009 q_x  out  20, q_y  out  24  candidate cell coordinates for board occupancy query; q_valid  out  1  query strobe.
REQ-010 q_hit  in  1  board response, valid exactly one cycle after q_valid; 1 = any queried cell occupied.
REQ-011 piece_x  out  20, piece_y  out  24  committed falling-piece coordinates, same packing; piece_valid  out  1.
REQ-012 lock_valid  out  1  piece locked, coordinates on piece_x/piece_y; lock_ready  in  1  board accepted lock (line clear done).
REQ-013 game_over  out  1; busy  out  1 (state not ACTIVE/IDLE/OVER); pieces  out  16  locked-piece count.

Function
REQ-014 States SHALL be IDLE, SPAWN, SPAWN_CHK, ACTIVE, CHK, LOCK, OVER.
REQ-015 IDLE: start=1 -> SPAWN next cycle; all else ignored.
REQ-016 SPAWN: load spawn_x/spawn_y into candidate, drive q_x/q_y = candidate, q_valid=1 for one cycle -> SPAWN_CHK.
REQ-017 SPAWN_CHK: q_hit=1 -> OVER; q_hit=0 -> commit candidate to piece_x/piece_y, piece_valid=1 -> ACTIVE.
REQ-018 ACTIVE move priority: tick or req_down (treated as one down move) > req_left > req_right; at most one move per cycle.
REQ-019 Candidate: down = all y+1; left = all x-1; right = all x+1; x unchanged for down, y unchanged for left/right.
REQ-020 Bounds check combinational, no query: left with any x=0, right with any x=BOARD_W-1 -> discard, stay ACTIVE; down with any y=BOARD_H-1 -> LOCK.
REQ-021 In-bounds candidate: q_valid=1 with q_x/q_y = candidate for one cycle -> CHK.
REQ-022 CHK: q_hit=0 -> commit candidate, -> ACTIVE; q_hit=1 and move was down -> LOCK; q_hit=1 otherwise -> ACTIVE, piece unchanged.
REQ-023 Requests and ticks arriving outside ACTIVE SHALL be dropped, never queued.
REQ-024 LOCK: lock_valid=1, piece_x/piece_y held; transfer when lock_valid and lock_ready both 1 in the same cycle -> pieces increments, piece_valid=0, -> SPAWN.
REQ-025 lock_ready=1 in the LOCK entry cycle SHALL complete the transfer that cycle (zero-wait accept).
REQ-026 pieces SHALL saturate at 16'hFFFF.
REQ-027 OVER: game_over=1, piece_valid=0; start=1 -> clear game_over and pieces, -> SPAWN.
REQ-028 q_valid SHALL be 0 in every state except the issuing cycle of SPAWN or ACTIVE; q_x/q_y are don't-care when q_valid=0.
REQ-029 Coordinate arithmetic SHALL be per-field 5-bit x / 6-bit y; bounds check guarantees no wrap.

Reset
REQ-030 Reset=1 at a clock edge SHALL force IDLE, piece_x/piece_y/pieces = 0, piece_valid, q_valid, lock_valid, game_over = 0, from any state including CHK and LOCK mid-handshake.
REQ-031 A pending q_hit in the cycle after reset SHALL be ignored.

Verification
REQ-032 Reset, start, spawn O (x 9,10,9,10 y 0,0,1,1), q_hit=0 -> piece_valid=1 third cycle after start, piece_y = 0,0,1,1.
REQ-033 ACTIVE, tick with q_hit=0 -> piece_y = 1,1,2,2 two cycles later; tick and req_left same cycle -> only down move.
REQ-034 I piece at x 0,1,2,3, req_left -> no q_valid, piece unchanged, state ACTIVE.
REQ-035 Piece bottom at y=23, tick -> LOCK without query; lock_ready held 0 three cycles -> lock_valid stays 1; lock_ready=1 -> pieces +1, next cycle SPAWN.
REQ-036 Spawn with q_hit=1 -> game_over=1, piece_valid=0; start -> game_over=0, pieces=0, new spawn query.
REQ-037 Reset asserted in CHK with q_hit=1 following -> IDLE, all outputs 0, no commit.
